game_status_ctrl: RTL and testbench
===================================

# game_status_ctrl

Game-progress controller that owns the current stage number and remaining life count consumed by the UI overlay renderer. It sits directly upstream of the UI display stage. It turns single-cycle gameplay events (start, player hit, stage cleared) and the per-frame tick into registered `stage` / `life` values plus status flags. Stage 0 is the start screen, stages 1..NUM_STAGES are played in order, and life 0 means game over.

## Interface
- `MAX_LIFE`, 5: life count loaded at reset/restart; 1..7.
- `NUM_STAGES`, 10: last playable stage; 1..15.
- `INVULN_FRAMES`, 60: frame ticks of invulnerability after a non-fatal hit; 1..255.
- `PAUSE_FRAMES`, 120: frame ticks of pause after a stage clear; 1..255.

- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset; clock `clk`.
- `frame_tick` in 1: one-cycle pulse per video frame (vsync).
- `start` in 1: one-cycle pulse, debounced start button.
- `hit` in 1: one-cycle pulse, player collision.
- `stage_clear` in 1: one-cycle pulse, all targets in the stage destroyed.
- `stage` out 4: current stage, 0..NUM_STAGES.
- `life` out 3: remaining lives, 0..MAX_LIFE.
- `playing` out 1: high in PLAY and HIT; gameplay logic is enabled.
- `invuln` out 1: high in HIT.
- `game_over` out 1: high in OVER.
- `win` out 1: high in WIN.

## Operation
- States: IDLE, PLAY, HIT, CLEAR, OVER, WIN. All outputs are registered and decoded from state.
- Frame counter: 8 bits, unsigned.
- IDLE: `stage`=0, `life`=MAX_LIFE.
  - `start` → PLAY, `stage`=1.
- PLAY:
  - `stage_clear` → CLEAR, counter=PAUSE_FRAMES.
  - Else `hit` with `life`==1 → OVER, `life`=0.
  - Else `hit` → HIT, `life` decremented by 1, counter=INVULN_FRAMES.
  - When `stage_clear` and `hit` arrive in the same cycle, `stage_clear` wins and the hit is discarded.
- HIT:
  - `hit` is ignored.
  - Each `frame_tick` decrements the counter. The tick that finds counter==1 → PLAY.
  - `stage_clear` → CLEAR (counter reloads to PAUSE_FRAMES) and has priority over the tick.
- CLEAR:
  - `hit` and `stage_clear` are ignored.
  - Each `frame_tick` decrements the counter. The tick that finds counter==1:
    - if `stage`==NUM_STAGES → WIN, `stage` unchanged;
    - else → PLAY with `stage`+1.
- OVER: `start` → IDLE (`stage`=0, `life`=MAX_LIFE).
- WIN: `start` → IDLE (`stage`=0, `life`=MAX_LIFE).
- `start` is ignored in PLAY, HIT and CLEAR.
- `life` never underflows. It is 0 only in OVER.
- `stage` never exceeds NUM_STAGES and never wraps.
- A `frame_tick` in IDLE, PLAY, OVER or WIN has no effect.

## Timing
- Reset (reset_n low at a rising edge): state=IDLE, `stage`=0, `life`=MAX_LIFE, counter=0, `playing`=0, `invuln`=0, `game_over`=0, `win`=0.
- Reset mid-operation (HIT or CLEAR) aborts immediately, with no residual counter effect.
- Latency: an event sampled at edge N is visible on every output after edge N (1 cycle).
- HIT lasts exactly INVULN_FRAMES `frame_tick` pulses.
- CLEAR lasts exactly PAUSE_FRAMES `frame_tick` pulses.
- Pulses are sampled every cycle. A pulse held high for k cycles counts as k events, but state gating makes repeats harmless except `start` in OVER/WIN. `start` held for 2 cycles in OVER gives IDLE and then PLAY.

## Configuration
- Macro: `GAME_STATUS_EXTRA_LIFE_EN`.
- Defined: on every CLEAR→PLAY transition, `life` = min(`life`+1, MAX_LIFE), in the same cycle as the `stage` increment. Not applied on CLEAR→WIN.
- Undefined: `life` is unchanged across a stage clear.

## Test plan
- Reset, then `start` → next cycle `stage`=1, `life`=5, `playing`=1, `invuln`=0.
- In PLAY, `hit` → `life`=4, `invuln`=1. 59 `frame_tick`s: still `invuln`=1. 60th tick → `invuln`=0. Any `hit` during HIT leaves `life`=4.
- 5 hits, each separated by 60 ticks → `life` 4,3,2,1, then the 5th hit gives `life`=0, `game_over`=1, `playing`=0. Then `start` → `stage`=0, `life`=5.
- `hit` and `stage_clear` in the same cycle at `life`=3 → `life` stays 3, state CLEAR. After 120 ticks → `stage`+1, PLAY. With `GAME_STATUS_EXTRA_LIFE_EN` defined → `life`=4.
- Clear stages 1..10 in sequence → `stage` reaches 10. The final clear plus 120 ticks → `win`=1, `stage`=10.
- Assert `reset_n` low for 1 cycle during CLEAR → all outputs at reset values on the next cycle. Stray `frame_tick`s in IDLE have no effect.

Source files
------------

// File: rtl/game_status_ctrl.sv
// Game progress controller: stage, lives and status flags for the UI overlay.
// Optional GAME_STATUS_EXTRA_LIFE_EN grants one life (capped) per stage cleared.
module game_status_ctrl #(
   parameter int MAX_LIFE      = 5,
   parameter int NUM_STAGES    = 10,
   parameter int INVULN_FRAMES = 60,
   parameter int PAUSE_FRAMES  = 120
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       hit,
   input  logic       stage_clear,
   output logic [3:0] stage,
   output logic [2:0] life,
   output logic       playing,
   output logic       invuln,
   output logic       game_over,
   output logic       win
);

   typedef enum logic [2:0] {
      IDLE, PLAY, HIT, CLEAR, OVER, WIN
   } state_t;

   state_t     state, state_nx;
   logic [3:0] stage_nx;
   logic [2:0] life_nx;
   logic [7:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         stage <= 4'd0;
         life  <= 3'(MAX_LIFE);
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         stage <= stage_nx;
         life  <= life_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      stage_nx = stage;
      life_nx  = life;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            stage_nx = 4'd0;
            life_nx  = 3'(MAX_LIFE);
            if (start) begin
               state_nx = PLAY;
               stage_nx = 4'd1;
            end
         end
         PLAY: begin
            // A simultaneous hit is dropped in favour of the clear
            if (stage_clear) begin
               state_nx = CLEAR;
               cnt_nx   = 8'(PAUSE_FRAMES);
            end else if (hit && life == 3'd1) begin
               state_nx = OVER;
               life_nx  = 3'd0;
            end else if (hit) begin
               state_nx = HIT;
               life_nx  = life - 3'd1;
               cnt_nx   = 8'(INVULN_FRAMES);
            end
         end
         HIT: begin
            if (stage_clear) begin
               state_nx = CLEAR;
               cnt_nx   = 8'(PAUSE_FRAMES);
            end else if (frame_tick) begin
               cnt_nx = cnt - 8'd1;
               if (cnt == 8'd1)
                  state_nx = PLAY;
            end
         end
         CLEAR: begin
            if (frame_tick) begin
               cnt_nx = cnt - 8'd1;
               if (cnt == 8'd1) begin
                  if (stage == 4'(NUM_STAGES)) begin
                     state_nx = WIN;
                  end else begin
                     state_nx = PLAY;
                     stage_nx = stage + 4'd1;
`ifdef GAME_STATUS_EXTRA_LIFE_EN
                     if (life < 3'(MAX_LIFE))
                        life_nx = life + 3'd1;
`endif
                  end
               end
            end
         end
         OVER, WIN: begin
            if (start) begin
               state_nx = IDLE;
               stage_nx = 4'd0;
               life_nx  = 3'(MAX_LIFE);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      playing   = 1'b0;
      invuln    = 1'b0;
      game_over = 1'b0;
      win       = 1'b0;
      unique case (state)
         PLAY:    playing = 1'b1;
         HIT: begin
            playing = 1'b1;
            invuln  = 1'b1;
         end
         OVER:    game_over = 1'b1;
         WIN:     win = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl: vector table plus multi-cycle sequences.
// Expected lives follow GAME_STATUS_EXTRA_LIFE_EN when it is defined.
module tb_game_status_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic       stage_clear = 1'b0;
   logic [3:0] stage;
   logic [2:0] life;
   logic       playing, invuln, game_over, win;

   int checks = 0;
   int failures = 0;
   int exp_life;

   game_status_ctrl dut (
      .clk(clk),
      .reset_n(reset_n),
      .frame_tick(frame_tick),
      .start(start),
      .hit(hit),
      .stage_clear(stage_clear),
      .stage(stage),
      .life(life),
      .playing(playing),
      .invuln(invuln),
      .game_over(game_over),
      .win(win)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ft, st, ht, sc;
      logic [3:0] stage;
      logic [2:0] life;
      logic       p, i, g, w;
   } vec_t;

   vec_t tbl [9];

   task automatic step(input logic rn, input logic ft, input logic st,
                       input logic ht, input logic sc);
      @(negedge clk);
      reset_n     = rn;
      frame_tick  = ft;
      start       = st;
      hit         = ht;
      stage_clear = sc;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++)
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [3:0] es,
                        input logic [2:0] el, input logic ep,
                        input logic ei, input logic eg, input logic ew);
      logic [10:0] got, exp;
      got = {stage, life, playing, invuln, game_over, win};
      exp = {es, el, ep, ei, eg, ew};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got stage=%0d life=%0d p/i/g/w=%b%b%b%b, expected stage=%0d life=%0d p/i/g/w=%b%b%b%b",
                  name, stage, life, playing, invuln, game_over, win,
                  es, el, ep, ei, eg, ew);
      end
   endtask

   function automatic int bump(input int l);
`ifdef GAME_STATUS_EXTRA_LIFE_EN
      return (l < 5) ? l + 1 : l;
`else
      return l;
`endif
   endfunction

   initial begin
      // ft st ht sc | stage life | p i g w
      tbl[0] = {4'b1000, 4'd0, 3'd5, 4'b0000};
      tbl[1] = {4'b0100, 4'd1, 3'd5, 4'b1000};
      tbl[2] = {4'b0100, 4'd1, 3'd5, 4'b1000};
      tbl[3] = {4'b0010, 4'd1, 3'd4, 4'b1100};
      tbl[4] = {4'b0010, 4'd1, 3'd4, 4'b1100};
      tbl[5] = {4'b1000, 4'd1, 3'd4, 4'b1100};
      tbl[6] = {4'b0001, 4'd1, 3'd4, 4'b0000};
      tbl[7] = {4'b0010, 4'd1, 3'd4, 4'b0000};
      tbl[8] = {4'b0100, 4'd1, 3'd4, 4'b0000};

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset", 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int v = 0; v < 9; v++) begin
         step(1'b1, tbl[v].ft, tbl[v].st, tbl[v].ht, tbl[v].sc);
         check($sformatf("vec%0d", v), tbl[v].stage, tbl[v].life,
               tbl[v].p, tbl[v].i, tbl[v].g, tbl[v].w);
      end

      // Reset during CLEAR, then stray ticks in IDLE
      ticks(5);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_in_clear", 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(3);
      check("idle_ticks", 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("start", 4'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int h = 1; h <= 4; h++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         check($sformatf("hit%0d", h), 4'd1, 3'(5 - h), 1'b1, 1'b1, 1'b0, 1'b0);
         ticks(59);
         check($sformatf("hit%0d_t59", h), 4'd1, 3'(5 - h), 1'b1, 1'b1, 1'b0, 1'b0);
         ticks(1);
         check($sformatf("hit%0d_t60", h), 4'd1, 3'(5 - h), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("fatal_hit", 4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(2);
      check("over_ticks", 4'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("over_start1", 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("over_start2", 4'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int h = 0; h < 2; h++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         ticks(60);
      end
      check("life3", 4'd1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("hit_and_clear", 4'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(119);
      check("clear_t119", 4'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(1);
      exp_life = bump(3);
      check("clear_t120", 4'd2, 3'(exp_life), 1'b1, 1'b0, 1'b0, 1'b0);

      for (int s = 2; s < 10; s++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
         ticks(120);
         exp_life = bump(exp_life);
         check($sformatf("stage%0d", s + 1), 4'(s + 1), 3'(exp_life),
               1'b1, 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      ticks(120);
      check("win", 4'd10, 3'(exp_life), 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("win_hold", 4'd10, 3'(exp_life), 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("win_start", 4'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit 2000000 time units");
      $fatal(1, "timeout");
   end

endmodule
